// File: rtl/pipelined_alu.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides.
// Optional signed-overflow output enabled by defining PIPELINED_ALU_OVF_EN.
module pipelined_alu #(
  parameter  int WIDTH = 32,
  localparam int HALF  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             compare,
  output logic             illegal
`ifdef PIPELINED_ALU_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_XOR   = 5'b00100;
  localparam logic [4:0] OP_NAND  = 5'b00101;
  localparam logic [4:0] OP_NOR   = 5'b00110;
  localparam logic [4:0] OP_XNOR  = 5'b00111;
  localparam logic [4:0] OP_MVHI  = 5'b01000;
  localparam logic [4:0] OP_F     = 5'b01001;
  localparam logic [4:0] OP_EQ    = 5'b01010;
  localparam logic [4:0] OP_LT    = 5'b01011;
  localparam logic [4:0] OP_LTE   = 5'b01100;
  localparam logic [4:0] OP_T     = 5'b01101;
  localparam logic [4:0] OP_NE    = 5'b01110;
  localparam logic [4:0] OP_GTE   = 5'b01111;
  localparam logic [4:0] OP_GT    = 5'b10000;
  localparam logic [4:0] OP_BEQZ  = 5'b10001;
  localparam logic [4:0] OP_BLTZ  = 5'b10010;
  localparam logic [4:0] OP_BLTEZ = 5'b10011;
  localparam logic [4:0] OP_BNEZ  = 5'b10100;
  localparam logic [4:0] OP_BGTEZ = 5'b10101;
  localparam logic [4:0] OP_BGTZ  = 5'b10111;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [4:0]       r_op;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_compare;
  logic             r_illegal;

  logic             w_s2_load;
  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res_base;
  logic [WIDTH-1:0] w_res;
  logic             w_cmp;
  logic             w_cmp_op;
  logic             w_ill;
  logic             w_a_neg;
  logic             w_a_zero;
  logic             w_a_lt_b;
  logic             w_a_eq_b;

  // S2 may load whenever its slot is empty or being drained this cycle
  assign w_s2_load  = !r_out_valid | out_ready;
  assign w_in_ready = !r_s1_valid | w_s2_load;
  assign w_accept   = in_valid & w_in_ready;

  assign w_sum    = r_a + r_b;
  assign w_diff   = r_a - r_b;
  assign w_a_neg  = r_a[WIDTH-1];
  assign w_a_zero = (r_a == {WIDTH{1'b0}});
  assign w_a_lt_b = ($signed(r_a) < $signed(r_b));
  assign w_a_eq_b = (r_a == r_b);

  // Opcode decode and datapath evaluated from the S1 registers
  always_comb begin
    w_res_base = {WIDTH{1'b0}};
    w_cmp      = 1'b0;
    w_cmp_op   = 1'b0;
    w_ill      = 1'b0;
    case (r_op)
      OP_ADD:   w_res_base = w_sum;
      OP_SUB:   w_res_base = w_diff;
      OP_AND:   w_res_base = r_a & r_b;
      OP_OR:    w_res_base = r_a | r_b;
      OP_XOR:   w_res_base = r_a ^ r_b;
      OP_NAND:  w_res_base = ~(r_a & r_b);
      OP_NOR:   w_res_base = ~(r_a | r_b);
      OP_XNOR:  w_res_base = ~(r_a ^ r_b);
      OP_MVHI:  w_res_base = {r_b[HALF-1:0], {HALF{1'b0}}};
      OP_F:     begin w_cmp_op = 1'b1; w_cmp = 1'b0; end
      OP_EQ:    begin w_cmp_op = 1'b1; w_cmp = w_a_eq_b; end
      OP_LT:    begin w_cmp_op = 1'b1; w_cmp = w_a_lt_b; end
      OP_LTE:   begin w_cmp_op = 1'b1; w_cmp = w_a_lt_b | w_a_eq_b; end
      OP_T:     begin w_cmp_op = 1'b1; w_cmp = 1'b1; end
      OP_NE:    begin w_cmp_op = 1'b1; w_cmp = !w_a_eq_b; end
      OP_GTE:   begin w_cmp_op = 1'b1; w_cmp = !w_a_lt_b; end
      OP_GT:    begin w_cmp_op = 1'b1; w_cmp = !w_a_lt_b & !w_a_eq_b; end
      OP_BEQZ:  w_cmp = w_a_zero;
      OP_BLTZ:  w_cmp = w_a_neg;
      OP_BLTEZ: w_cmp = w_a_neg | w_a_zero;
      OP_BNEZ:  w_cmp = !w_a_zero;
      OP_BGTEZ: w_cmp = !w_a_neg;
      OP_BGTZ:  w_cmp = !w_a_neg & !w_a_zero;
      default:  w_ill = 1'b1;
    endcase
  end

  // Compares report their outcome through result as well; branches leave it zero
  assign w_res = w_cmp_op ? {{(WIDTH-1){1'b0}}, w_cmp} : w_res_base;

`ifdef PIPELINED_ALU_OVF_EN
  logic w_ovf;
  logic r_overflow;

  assign w_ovf = ((r_op == OP_ADD) && (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1]  != r_a[WIDTH-1])) ||
                 ((r_op == OP_SUB) && (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]));

  // Overflow flag travels with the S2 result
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_s2_load && r_s1_valid) begin
      r_overflow <= w_ovf;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign overflow = r_overflow;
`endif

  // Stage 1: capture operands on accept, drop the entry once S2 takes it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= {WIDTH{1'b0}};
      r_b        <= {WIDTH{1'b0}};
      r_op       <= 5'b00000;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_a        <= a;
      r_b        <= b;
      r_op       <= op;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= r_s1_valid;
    end
  end

  // Stage 2: result registers only change when an S1 entry moves in
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_compare   <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result  <= w_res;
        r_compare <= w_cmp;
        r_illegal <= w_ill;
      end else begin
        r_result  <= r_result;
        r_compare <= r_compare;
        r_illegal <= r_illegal;
      end
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign compare   = r_compare;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed, table-driven bench for pipelined_alu (32-bit and 16-bit instances).
module tb_pipelined_alu;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, AND_ = 5'b00010, OR_ = 5'b00011;
  localparam logic [4:0] XOR_ = 5'b00100, NAND_ = 5'b00101, NOR_ = 5'b00110, XNOR_ = 5'b00111;
  localparam logic [4:0] MVHI = 5'b01000, F = 5'b01001, EQ = 5'b01010, LT = 5'b01011;
  localparam logic [4:0] LTE = 5'b01100, T = 5'b01101, NE = 5'b01110, GTE = 5'b01111, GT = 5'b10000;
  localparam logic [4:0] BEQZ = 5'b10001, BLTZ = 5'b10010, BLTEZ = 5'b10011, BNEZ = 5'b10100;
  localparam logic [4:0] BGTEZ = 5'b10101, BGTZ = 5'b10111;

  logic        clk;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, compare, illegal;
  logic [31:0] a, b, result;
  logic [4:0]  op;
  logic        in_valid16, in_ready16, out_valid16, out_ready16, compare16, illegal16;
  logic [15:0] a16, b16, result16;
  logic [4:0]  op16;
`ifdef PIPELINED_ALU_OVF_EN
  logic        overflow, overflow16;
`endif

  int checks = 0;
  int errors = 0;

  pipelined_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .compare(compare), .illegal(illegal)
`ifdef PIPELINED_ALU_OVF_EN
    , .overflow(overflow)
`endif
  );

  pipelined_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .compare(compare16), .illegal(illegal16)
`ifdef PIPELINED_ALU_OVF_EN
    , .overflow(overflow16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cmp;
    logic        ill;
    logic        ovf;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int n;
    chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 5) begin
      step();
      n++;
    end
    chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
    chk($sformatf("v%0d result", i), result, vecs[i].res);
    chk($sformatf("v%0d compare", i), {31'd0, compare}, {31'd0, vecs[i].cmp});
    chk($sformatf("v%0d illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
`ifdef PIPELINED_ALU_OVF_EN
    chk($sformatf("v%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
`endif
    step();
  endtask

  initial begin
    int sent, recv;
    logic [31:0] prev_res;
    logic have_prev;

    vecs[0]  = '{ADD,   32'd55,         32'd109,        32'd164,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{SUB,   32'd55,         32'd109,        32'hFFFF_FFCA,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{AND_,  32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OR_,   32'hF0F0_1234,  32'h0FF0_FF00,  32'hFFF0_FF34,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{XOR_,  32'hF0F0_1234,  32'h0FF0_FF00,  32'hFF00_ED34,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{NAND_, 32'hF0F0_1234,  32'h0FF0_FF00,  32'hFF0F_EDFF,  1'b0, 1'b0, 1'b0};
    vecs[6]  = '{NOR_,  32'hF0F0_1234,  32'h0FF0_FF00,  32'h000F_00CB,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{XNOR_, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00FF_12CB,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{MVHI,  32'd0,          32'hABCD_1234,  32'h1234_0000,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{LT,    32'd55,         32'd109,        32'd1,          1'b1, 1'b0, 1'b0};
    vecs[10] = '{GTE,   32'd55,         32'd109,        32'd0,          1'b0, 1'b0, 1'b0};
    vecs[11] = '{EQ,    32'd55,         32'd109,        32'd0,          1'b0, 1'b0, 1'b0};
    vecs[12] = '{T,     32'd55,         32'd109,        32'd1,          1'b1, 1'b0, 1'b0};
    vecs[13] = '{F,     32'd55,         32'd109,        32'd0,          1'b0, 1'b0, 1'b0};
    vecs[14] = '{LT,    32'hFFFF_FFFF,  32'd1,          32'd1,          1'b1, 1'b0, 1'b0};
    vecs[15] = '{GT,    32'd109,        32'd55,         32'd1,          1'b1, 1'b0, 1'b0};
    vecs[16] = '{LTE,   32'd55,         32'd55,         32'd1,          1'b1, 1'b0, 1'b0};
    vecs[17] = '{NE,    32'd55,         32'd109,        32'd1,          1'b1, 1'b0, 1'b0};
    vecs[18] = '{BEQZ,  32'hFFFF_FFF3,  32'd5,          32'd0,          1'b0, 1'b0, 1'b0};
    vecs[19] = '{BLTZ,  32'hFFFF_FFF3,  32'd5,          32'd0,          1'b1, 1'b0, 1'b0};
    vecs[20] = '{BLTEZ, 32'hFFFF_FFF3,  32'd5,          32'd0,          1'b1, 1'b0, 1'b0};
    vecs[21] = '{BNEZ,  32'hFFFF_FFF3,  32'd5,          32'd0,          1'b1, 1'b0, 1'b0};
    vecs[22] = '{BGTEZ, 32'hFFFF_FFF3,  32'd5,          32'd0,          1'b0, 1'b0, 1'b0};
    vecs[23] = '{BGTZ,  32'hFFFF_FFF3,  32'd5,          32'd0,          1'b0, 1'b0, 1'b0};
    vecs[24] = '{BEQZ,  32'd0,          32'd5,          32'd0,          1'b1, 1'b0, 1'b0};
    vecs[25] = '{BGTZ,  32'd5,          32'd0,          32'd0,          1'b1, 1'b0, 1'b0};
    vecs[26] = '{5'b10110, 32'd3,       32'd4,          32'd0,          1'b0, 1'b1, 1'b0};
    vecs[27] = '{5'b11111, 32'd3,       32'd4,          32'd0,          1'b0, 1'b1, 1'b0};
    vecs[28] = '{ADD,   32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b0, 1'b1};
    vecs[29] = '{SUB,   32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1};
    vecs[30] = '{ADD,   32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0; op = 5'd0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = 16'd0; b16 = 16'd0; op16 = 5'd0;
    step(); step();
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst compare", {31'd0, compare}, 32'd0);
    chk("rst illegal", {31'd0, illegal}, 32'd0);
`ifdef PIPELINED_ALU_OVF_EN
    chk("rst overflow", {31'd0, overflow}, 32'd0);
`endif
    reset_n = 1'b1;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Back-to-back ADD then SUB: latency two cycles, one result per cycle
    out_ready = 1'b1; in_valid = 1'b1; a = 32'd55; b = 32'd109; op = ADD;
    step();
    chk("lat N+1 out_valid", {31'd0, out_valid}, 32'd0);
    op = SUB;
    step();
    in_valid = 1'b0;
    chk("lat N+2 out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat N+2 result", result, 32'd164);
    chk("lat N+2 compare", {31'd0, compare}, 32'd0);
    step();
    chk("lat N+3 out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat N+3 result", result, 32'hFFFF_FFCA);
    step();
    chk("lat drain out_valid", {31'd0, out_valid}, 32'd0);

    // Streaming under backpressure
    sent = 0; recv = 0; have_prev = 1'b0; prev_res = 32'd0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid = (sent < 4);
      a = sent; b = 32'd1; op = ADD;
      #1;
      if (cyc == 2) begin
        chk("stream in_ready stalled", {31'd0, in_ready}, 32'd0);
        chk("stream accepts before stall", sent, 32'd2);
      end
      if (out_valid && !out_ready && have_prev) chk("stream stable", result, prev_res);
      if (out_valid && out_ready) begin
        chk($sformatf("stream res%0d", recv), result, recv + 1);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      prev_res = result;
      have_prev = out_valid;
      step();
    end
    in_valid = 1'b0;
    chk("stream count", recv, 32'd4);
    chk("stream idle", {31'd0, out_valid}, 32'd0);

    // Reset while both stages are full and stalled
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd7; b = 32'd1; op = ADD;
    step();
    a = 32'd8;
    step();
    in_valid = 1'b0;
    chk("full out_valid", {31'd0, out_valid}, 32'd1);
    chk("full in_ready", {31'd0, in_ready}, 32'd0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst result", result, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no stale output", {31'd0, out_valid}, 32'd0);
    end

    // 16-bit instance
    in_valid16 = 1'b1; a16 = 16'd0; b16 = 16'h0012; op16 = MVHI;
    step();
    a16 = 16'h8000; b16 = 16'd1; op16 = LT;
    step();
    in_valid16 = 1'b0;
    chk("w16 mvhi valid", {31'd0, out_valid16}, 32'd1);
    chk("w16 mvhi result", {16'd0, result16}, 32'h0000_1200);
    step();
    chk("w16 lt result", {16'd0, result16}, 32'd1);
    chk("w16 lt compare", {31'd0, compare16}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
